// File: rtl/fpga250_cfg_pkg.sv
// Shared configuration-interface constants and helpers for the fabric-side
// config chain receiver.
package fpga250_cfg_pkg;

    localparam int CFG_LANES     = 4;
    localparam int CFG_LANE_BITS = 64;

    // Counter must hold 0..LANE_BITS+1, where LANE_BITS+1 marks an overflowed load.
    function automatic int cfg_cnt_width(input int lane_bits);
        return $clog2(lane_bits + 2);
    endfunction

endpackage

// File: rtl/config_lane_rx.sv
// One configuration lane: serial shift register, saturating bit counter,
// set-edge detection and the committed configuration register with status flags.
module config_lane_rx
    import fpga250_cfg_pkg::*;
#(
    parameter int LANE_BITS = CFG_LANE_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 set,
    input  logic                 shift,
    output logic [LANE_BITS-1:0] cfg,
    output logic                 shift_tail,
    output logic                 configured,
    output logic                 error
);

    localparam int             CW       = cfg_cnt_width(LANE_BITS);
    localparam logic [CW-1:0]  CNT_FULL = CW'(LANE_BITS);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(LANE_BITS + 1);

    logic [LANE_BITS-1:0] sr;
    logic [CW-1:0]        cnt;
    logic                 set_q;
    logic                 set_rise;

    assign set_rise   = set & ~set_q;
    assign shift_tail = sr[LANE_BITS-1];

    // set_q resets high so a set held across reset release is not seen as a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            set_q      <= 1'b1;
            cfg        <= '0;
            configured <= 1'b0;
            error      <= 1'b0;
        end else begin
            set_q <= set;
            if (cen) begin
                sr <= {sr[LANE_BITS-2:0], shift};
            end
            // A commit samples the pre-shift register and count; a concurrent
            // shift becomes the first bit of the next load.
            if (set_rise) begin
                cfg        <= sr;
                configured <= (cnt == CNT_FULL);
                error      <= (cnt != CNT_FULL);
                cnt        <= cen ? CW'(1) : '0;
            end else if (cen && (cnt != CNT_SAT)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/config_chain_receiver.sv
// Fabric-side receiver for the Wishbone configurator's cen/set/shift lanes:
// one config_lane_rx per lane, outputs concatenated lane by lane.
module config_chain_receiver
    import fpga250_cfg_pkg::*;
#(
    parameter int LANES     = CFG_LANES,
    parameter int LANE_BITS = CFG_LANE_BITS
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       cen_i,
    input  logic [LANES-1:0]           set_i,
    input  logic [LANES-1:0]           shift_i,
    output logic [LANES*LANE_BITS-1:0] config_o,
    output logic [LANES-1:0]           shift_tail_o,
    output logic [LANES-1:0]           configured_o,
    output logic [LANES-1:0]           error_o
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        config_lane_rx #(
            .LANE_BITS(LANE_BITS)
        ) u_lane (
            .clk        (wb_clk_i),
            .rst        (wb_rst_i),
            .cen        (cen_i),
            .set        (set_i[i]),
            .shift      (shift_i[i]),
            .cfg        (config_o[i*LANE_BITS +: LANE_BITS]),
            .shift_tail (shift_tail_o[i]),
            .configured (configured_o[i]),
            .error      (error_o[i])
        );
    end

endmodule

// File: doc/config_chain_receiver.md
# config_chain_receiver

Fabric-side consumer of the configuration interface driven by the Wishbone configurator: it receives the `cen` / `set` / `shift` lanes and deserialises each lane into a shift register. On each per-lane `set` edge it transfers that register into a held configuration register that feeds the FPGA tiles. It also checks that each lane received exactly the expected number of bits, and forwards each lane's tail bit for daisy-chaining to further receivers.

## Interface
Parameters:
- `LANES`, 4, number of independent config lanes (matches `shift_out`/`set_out` width).
- `LANE_BITS`, 64, bits per lane shift register; must be ≥ 2.

Ports:
- `wb_clk_i`  in  1  single clock; all state updates on its rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `cen_i`  in  1  config enable; when high, every lane shifts one bit per cycle.
- `set_i`  in  LANES  per-lane latch request; rising edge commits that lane.
- `shift_i`  in  LANES  per-lane serial data, sampled when `cen_i`=1.
- `config_o`  out  LANES*LANE_BITS  committed configuration; lane i occupies bits [i*LANE_BITS +: LANE_BITS].
- `shift_tail_o`  out  LANES  MSB of each lane shift register, for chaining.
- `configured_o`  out  LANES  lane has committed a correctly sized load.
- `error_o`  out  LANES  last commit on lane had bit count ≠ LANE_BITS.

## Operation
- Shift: when `cen_i`=1, lane i does `sr <= {sr[LANE_BITS-2:0], shift_i[i]}`. The first bit shifted ends at the MSB after LANE_BITS shifts. When `cen_i`=0, `sr` holds.
- Bit counter per lane, width clog2(LANE_BITS+2):
  - increments on each shift;
  - saturates at LANE_BITS+1 (overflow marker, never wraps).
- Set edge: `set_q` is a registered copy of `set_i`; a rise is `set_i[i] & ~set_q[i]`. A held-high `set_i` commits only once.
- On a rise for lane i:
  - `config_o` lane i <= `sr` as it was before this edge;
  - `configured_o[i]` <= (count == LANE_BITS);
  - `error_o[i]` <= (count != LANE_BITS);
  - count <= `cen_i` ? 1 : 0.
- `set_i` is independent of `cen_i`. A commit with count 0 is legal and flags `error_o`.
- Lanes are fully independent; any combination of simultaneous rises is supported.

## Timing
- Reset values:
  - `sr` = 0, `config_o` = 0, `shift_tail_o` = 0, counters = 0;
  - `configured_o` = 0, `error_o` = 0;
  - `set_q` = all ones, so a `set_i` held high across reset release does not commit.
- Shift latency: a bit sampled at edge N appears at `shift_tail_o` after edge N+LANE_BITS-1.
- Commit latency: `set_i` high at edge N (rise detected) → `config_o`/`configured_o`/`error_o` valid after edge N. Outputs are registered, with no combinational path from inputs.
- Simultaneous shift and rise at the same edge: commit uses pre-shift `sr` and pre-shift count; the shift still occurs; the new count = 1.
- Reset mid-load: everything returns to reset values at that edge, including already committed `config_o`.
- `config_o` changes only on a commit or on reset.

## Structure
- Shared package `fpga250_cfg_pkg`:
  - `CFG_LANES` = 4, `CFG_LANE_BITS` defaults;
  - a count-width function, clog2(LANE_BITS+2).
- Sub-module `config_lane_rx`: one lane, holding its shift register, counter, edge detect, commit register and flags. The top generates LANES instances and concatenates their outputs.

## Test plan
- Reset with `set_i`=4'hF held through release → no commit; `config_o`=0, `configured_o`=0, `error_o`=0.
- `cen_i`=1 for 64 cycles with lane 0 pattern 64'hDEAD_BEEF_0123_4567 (MSB first), then pulse `set_i[0]` → lane 0 `config_o`=64'hDEAD_BEEF_0123_4567, `configured_o`=4'b0001, `error_o`=0.
- Shift 63 bits on lane 1 and commit → `error_o[1]`=1, `configured_o[1]`=0; shift 70 bits and commit → counter saturated at 65, `error_o[1]`=1.
- Lane 2: `set_i[2]` rises on the same edge as the 65th shift, after a full 64-bit load → commit holds the first 64 bits; the next commit after 63 further shifts (count 64) is clean.
- Hold `set_i[3]` high 10 cycles → exactly one commit; `shift_tail_o[3]` shows the first shifted bit exactly 63 cycles after it was sampled.
- Assert `wb_rst_i` mid-shift after two committed lanes → all outputs 0 the cycle after; a subsequent full load commits correctly.
